// File: rtl/cpu_pkg.sv
// Shared CPU definitions: memory op codes, MEM FSM states, widths.
package cpu_pkg;

   localparam int XLEN   = 32;
   localparam int BE_W   = XLEN / 8;
   localparam int REG_AW = 5;

   typedef enum logic [3:0] {
      OP_NONE = 4'd0,
      OP_LB   = 4'd1,
      OP_LBU  = 4'd2,
      OP_LH   = 4'd3,
      OP_LHU  = 4'd4,
      OP_LW   = 4'd5,
      OP_SB   = 4'd6,
      OP_SH   = 4'd7,
      OP_SW   = 4'd8
   } mem_op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } mem_state_e;

endpackage

// File: rtl/mem_stage_if.sv
// Data-bus bundle between the MEM stage and the data memory.
interface mem_stage_if;
   import cpu_pkg::*;

   logic              dbus_req_o;
   logic              dbus_we_o;
   logic [XLEN-1:0]   dbus_addr_o;
   logic [XLEN-1:0]   dbus_wdata_o;
   logic [BE_W-1:0]   dbus_be_o;
   logic              dbus_ack_i;
   logic [XLEN-1:0]   dbus_rdata_i;

   modport master (
      output dbus_req_o, dbus_we_o, dbus_addr_o,
      output dbus_wdata_o, dbus_be_o,
      input  dbus_ack_i, dbus_rdata_i
   );

   modport slave (
      input  dbus_req_o, dbus_we_o, dbus_addr_o,
      input  dbus_wdata_o, dbus_be_o,
      output dbus_ack_i, dbus_rdata_i
   );

endinterface

// File: rtl/mem_align_unit.sv
// Op decode, alignment check, byte enables, store replication
// and load lane extraction; purely combinational.
module mem_align_unit
   import cpu_pkg::*;
(
   input  logic [3:0]      op,
   input  logic [XLEN-1:0] addr,
   input  logic [XLEN-1:0] store_data,
   input  logic [XLEN-1:0] rdata,
   output logic            is_mem,
   output logic            is_store,
   output logic            misaligned,
   output logic [BE_W-1:0] be,
   output logic [XLEN-1:0] wdata,
   output logic [XLEN-1:0] load_data
);

   logic            byte_op;
   logic            half_op;
   logic            word_op;
   logic            sgn;
   logic [XLEN-1:0] shifted;
   logic [7:0]      lane_b;
   logic [15:0]     lane_h;

   // Decode op code; unlisted codes fall through as no-op.
   always_comb begin
      byte_op  = 1'b0;
      half_op  = 1'b0;
      word_op  = 1'b0;
      sgn      = 1'b0;
      is_store = 1'b0;
      unique case (op)
         OP_LB:   begin byte_op = 1'b1; sgn = 1'b1; end
         OP_LBU:  byte_op = 1'b1;
         OP_LH:   begin half_op = 1'b1; sgn = 1'b1; end
         OP_LHU:  half_op = 1'b1;
         OP_LW:   word_op = 1'b1;
         OP_SB:   begin byte_op = 1'b1; is_store = 1'b1; end
         OP_SH:   begin half_op = 1'b1; is_store = 1'b1; end
         OP_SW:   begin word_op = 1'b1; is_store = 1'b1; end
         default: ;
      endcase
   end

   assign is_mem     = byte_op | half_op | word_op;
   assign misaligned = (half_op & addr[0]) |
                       (word_op & (|addr[1:0]));

   // Byte enables and replicated store data per access size.
   always_comb begin
      be    = '0;
      wdata = '0;
      unique case (1'b1)
         byte_op: begin
            be    = 4'b0001 << addr[1:0];
            wdata = {4{store_data[7:0]}};
         end
         half_op: begin
            be    = addr[1] ? 4'b1100 : 4'b0011;
            wdata = {2{store_data[15:0]}};
         end
         word_op: begin
            be    = 4'b1111;
            wdata = store_data;
         end
         default: ;
      endcase
   end

   assign shifted = rdata >> {addr[1:0], 3'b000};
   assign lane_b  = shifted[7:0];
   assign lane_h  = addr[1] ? rdata[31:16] : rdata[15:0];

   // Pick the addressed lane and sign- or zero-extend it.
   always_comb begin
      load_data = rdata;
      unique case (1'b1)
         byte_op: load_data = {{24{sgn & lane_b[7]}}, lane_b};
         half_op: load_data = {{16{sgn & lane_h[15]}}, lane_h};
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues data-bus transactions, stalls the
// front of the pipe until ack, and registers results for WB.
module mem_stage
   import cpu_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_write_reg_en_i,
   input  logic [REG_AW-1:0] mem_write_reg_addr_i,
   input  logic [XLEN-1:0]   mem_write_reg_data_i,
   input  logic [3:0]        mem_op_i,
   input  logic [XLEN-1:0]   mem_addr_i,
   input  logic [XLEN-1:0]   mem_store_data_i,
   mem_stage_if.master       dbus,
   output logic              stall_req_o,
   output logic              wb_write_reg_en_o,
   output logic [REG_AW-1:0] wb_write_reg_addr_o,
   output logic [XLEN-1:0]   wb_write_reg_data_o,
   output logic              mem_align_err_o
);

   mem_state_e      state_q;
   mem_state_e      state_d;
   logic            is_mem;
   logic            is_store;
   logic            misaligned;
   logic [BE_W-1:0] be;
   logic [XLEN-1:0] wdata;
   logic [XLEN-1:0] load_data;

   mem_align_unit u_align (
      .op         (mem_op_i),
      .addr       (mem_addr_i),
      .store_data (mem_store_data_i),
      .rdata      (dbus.dbus_rdata_i),
      .is_mem     (is_mem),
      .is_store   (is_store),
      .misaligned (misaligned),
      .be         (be),
      .wdata      (wdata),
      .load_data  (load_data)
   );

   // Next state and stall: stall until the ack cycle, never in reset.
   always_comb begin
      state_d     = state_q;
      stall_req_o = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (is_mem && !misaligned) begin
               state_d     = ST_BUSY;
               stall_req_o = 1'b1;
            end
         end
         ST_BUSY: begin
            if (dbus.dbus_ack_i) state_d = ST_IDLE;
            else stall_req_o = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
      if (rst) stall_req_o = 1'b0;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else state_q <= state_d;
   end

   // Bus request, write-back and error registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         dbus.dbus_req_o     <= 1'b0;
         dbus.dbus_we_o      <= 1'b0;
         dbus.dbus_addr_o    <= '0;
         dbus.dbus_wdata_o   <= '0;
         dbus.dbus_be_o      <= '0;
         wb_write_reg_en_o   <= 1'b0;
         wb_write_reg_addr_o <= '0;
         wb_write_reg_data_o <= '0;
         mem_align_err_o     <= 1'b0;
      end else begin
         mem_align_err_o <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (!is_mem) begin
                  wb_write_reg_en_o   <= mem_write_reg_en_i;
                  wb_write_reg_addr_o <= mem_write_reg_addr_i;
                  wb_write_reg_data_o <= mem_write_reg_data_i;
               end else if (misaligned) begin
                  wb_write_reg_en_o <= 1'b0;
                  mem_align_err_o   <= 1'b1;
               end else begin
                  dbus.dbus_req_o   <= 1'b1;
                  dbus.dbus_we_o    <= is_store;
                  dbus.dbus_addr_o  <= {mem_addr_i[31:2], 2'b00};
                  dbus.dbus_be_o    <= be;
                  dbus.dbus_wdata_o <= wdata;
                  wb_write_reg_en_o <= 1'b0;
               end
            end
            ST_BUSY: begin
               if (dbus.dbus_ack_i) begin
                  dbus.dbus_req_o     <= 1'b0;
                  wb_write_reg_addr_o <= mem_write_reg_addr_i;
                  if (is_store) begin
                     wb_write_reg_en_o <= 1'b0;
                  end else begin
                     wb_write_reg_en_o   <= mem_write_reg_en_i;
                     wb_write_reg_data_o <= load_data;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: pass-through, loads, stores,
// misalignment, reset mid-transaction and back-to-back ops.
module tb_mem_stage;
   import cpu_pkg::*;

   logic        clk;
   logic        rst;
   logic        en;
   logic [4:0]  waddr;
   logic [31:0] wdat;
   logic [3:0]  op;
   logic [31:0] addr;
   logic [31:0] sdata;
   logic        stall;
   logic        wb_en;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        err;
   int          n_tests;
   int          n_fail;

   mem_stage_if bus ();

   mem_stage dut (
      .clk                  (clk),
      .rst                  (rst),
      .mem_write_reg_en_i   (en),
      .mem_write_reg_addr_i (waddr),
      .mem_write_reg_data_i (wdat),
      .mem_op_i             (op),
      .mem_addr_i           (addr),
      .mem_store_data_i     (sdata),
      .dbus                 (bus.master),
      .stall_req_o          (stall),
      .wb_write_reg_en_o    (wb_en),
      .wb_write_reg_addr_o  (wb_addr),
      .wb_write_reg_data_o  (wb_data),
      .mem_align_err_o      (err)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Directed sequence; inputs change 1 ns after each rising edge.
   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst = 1'b1;
      en = 1'b0; waddr = '0; wdat = '0;
      op = OP_NONE; addr = '0; sdata = '0;
      bus.dbus_ack_i = 1'b0;
      bus.dbus_rdata_i = '0;
      tick(); tick();
      chk("rst_req",   {31'b0, bus.dbus_req_o}, 32'd0);
      chk("rst_we",    {31'b0, bus.dbus_we_o}, 32'd0);
      chk("rst_addr",  bus.dbus_addr_o, 32'd0);
      chk("rst_wdata", bus.dbus_wdata_o, 32'd0);
      chk("rst_be",    {28'b0, bus.dbus_be_o}, 32'd0);
      chk("rst_wb_en", {31'b0, wb_en}, 32'd0);
      chk("rst_wb_ad", {27'b0, wb_addr}, 32'd0);
      chk("rst_wb_d",  wb_data, 32'd0);
      chk("rst_err",   {31'b0, err}, 32'd0);
      chk("rst_stall", {31'b0, stall}, 32'd0);
      rst = 1'b0;

      // Pass-through
      en = 1'b1; waddr = 5'd3; wdat = 32'hDEADBEEF;
      #1 chk("pt_stall", {31'b0, stall}, 32'd0);
      tick();
      chk("pt_wb_en", {31'b0, wb_en}, 32'd1);
      chk("pt_wb_ad", {27'b0, wb_addr}, 32'd3);
      chk("pt_wb_d",  wb_data, 32'hDEADBEEF);
      chk("pt_req",   {31'b0, bus.dbus_req_o}, 32'd0);

      // LB at 0x103, ack after two wait cycles
      op = OP_LB; addr = 32'h103; waddr = 5'd5; en = 1'b1;
      #1 chk("lb_stall1", {31'b0, stall}, 32'd1);
      tick();
      chk("lb_req",   {31'b0, bus.dbus_req_o}, 32'd1);
      chk("lb_we",    {31'b0, bus.dbus_we_o}, 32'd0);
      chk("lb_addr",  bus.dbus_addr_o, 32'h100);
      chk("lb_be",    {28'b0, bus.dbus_be_o}, 32'h8);
      chk("lb_wb_en", {31'b0, wb_en}, 32'd0);
      #1 chk("lb_stall2", {31'b0, stall}, 32'd1);
      tick();
      chk("lb_req_hold", {31'b0, bus.dbus_req_o}, 32'd1);
      chk("lb_be_hold",  {28'b0, bus.dbus_be_o}, 32'h8);
      #1 chk("lb_stall3", {31'b0, stall}, 32'd1);
      tick();
      bus.dbus_ack_i = 1'b1;
      bus.dbus_rdata_i = 32'h80FF7F01;
      #1 chk("lb_stall_ack", {31'b0, stall}, 32'd0);
      tick();
      bus.dbus_ack_i = 1'b0;
      op = OP_NONE; en = 1'b0;
      chk("lb_req_done", {31'b0, bus.dbus_req_o}, 32'd0);
      chk("lb_wb_en2",   {31'b0, wb_en}, 32'd1);
      chk("lb_wb_ad",    {27'b0, wb_addr}, 32'd5);
      chk("lb_wb_d",     wb_data, 32'hFFFFFF80);

      // SH at 0x202, ack in the first busy cycle
      op = OP_SH; addr = 32'h202; sdata = 32'h0000ABCD;
      #1 chk("sh_stall", {31'b0, stall}, 32'd1);
      tick();
      chk("sh_req",   {31'b0, bus.dbus_req_o}, 32'd1);
      chk("sh_we",    {31'b0, bus.dbus_we_o}, 32'd1);
      chk("sh_addr",  bus.dbus_addr_o, 32'h200);
      chk("sh_be",    {28'b0, bus.dbus_be_o}, 32'hC);
      chk("sh_wdata", bus.dbus_wdata_o, 32'hABCDABCD);
      bus.dbus_ack_i = 1'b1;
      #1 chk("sh_stall_ack", {31'b0, stall}, 32'd0);
      tick();
      bus.dbus_ack_i = 1'b0;
      op = OP_NONE;
      chk("sh_req_done", {31'b0, bus.dbus_req_o}, 32'd0);
      chk("sh_wb_en",    {31'b0, wb_en}, 32'd0);

      // Misaligned LW
      op = OP_LW; addr = 32'h101; en = 1'b1;
      #1 chk("mis_stall", {31'b0, stall}, 32'd0);
      tick();
      op = OP_NONE; en = 1'b0;
      chk("mis_err",   {31'b0, err}, 32'd1);
      chk("mis_req",   {31'b0, bus.dbus_req_o}, 32'd0);
      chk("mis_wb_en", {31'b0, wb_en}, 32'd0);
      tick();
      chk("mis_err_off", {31'b0, err}, 32'd0);

      // Reset while an LHU is outstanding, then a stale ack
      op = OP_LHU; addr = 32'h10; en = 1'b1; waddr = 5'd7;
      tick();
      chk("rm_req", {31'b0, bus.dbus_req_o}, 32'd1);
      rst = 1'b1;
      #1 chk("rm_stall_rst", {31'b0, stall}, 32'd0);
      tick();
      rst = 1'b0;
      op = OP_NONE; en = 1'b0; waddr = '0; wdat = '0;
      chk("rm_req0",   {31'b0, bus.dbus_req_o}, 32'd0);
      chk("rm_addr0",  bus.dbus_addr_o, 32'd0);
      chk("rm_be0",    {28'b0, bus.dbus_be_o}, 32'd0);
      chk("rm_wb_en0", {31'b0, wb_en}, 32'd0);
      chk("rm_wb_d0",  wb_data, 32'd0);
      tick();
      bus.dbus_ack_i = 1'b1;
      bus.dbus_rdata_i = 32'h0000FFFF;
      #1 chk("rm_stall_ack", {31'b0, stall}, 32'd0);
      tick();
      bus.dbus_ack_i = 1'b0;
      chk("rm_req1",   {31'b0, bus.dbus_req_o}, 32'd0);
      chk("rm_wb_en1", {31'b0, wb_en}, 32'd0);
      chk("rm_wb_d1",  wb_data, 32'd0);

      // LBU at 0x1, then SW straight after the ack
      op = OP_LBU; addr = 32'h1; en = 1'b1; waddr = 5'd9;
      tick();
      chk("bb_req1", {31'b0, bus.dbus_req_o}, 32'd1);
      chk("bb_be1",  {28'b0, bus.dbus_be_o}, 32'h2);
      bus.dbus_ack_i = 1'b1;
      bus.dbus_rdata_i = 32'h0000F000;
      tick();
      bus.dbus_ack_i = 1'b0;
      chk("bb_wb_d",  wb_data, 32'h000000F0);
      chk("bb_wb_en", {31'b0, wb_en}, 32'd1);
      chk("bb_wb_ad", {27'b0, wb_addr}, 32'd9);
      chk("bb_req0",  {31'b0, bus.dbus_req_o}, 32'd0);
      op = OP_SW; addr = 32'h300; sdata = 32'h12345678; en = 1'b0;
      #1 chk("bb_stall", {31'b0, stall}, 32'd1);
      tick();
      chk("bb_req2",  {31'b0, bus.dbus_req_o}, 32'd1);
      chk("bb_we2",   {31'b0, bus.dbus_we_o}, 32'd1);
      chk("bb_addr2", bus.dbus_addr_o, 32'h300);
      chk("bb_be2",   {28'b0, bus.dbus_be_o}, 32'hF);
      chk("bb_wd2",   bus.dbus_wdata_o, 32'h12345678);
      bus.dbus_ack_i = 1'b1;
      tick();
      bus.dbus_ack_i = 1'b0;
      op = OP_NONE;
      chk("bb_req_end", {31'b0, bus.dbus_req_o}, 32'd0);
      chk("bb_wb_en2",  {31'b0, wb_en}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
